// File: rtl/fifo_rd_stream_pkg.sv
// Shared definitions for the async FIFO read-side stream stage:
// buffer occupancy encoding and default widths.
package fifo_rd_stream_pkg;

   localparam int unsigned DSIZE_DEF = 8;
   localparam int unsigned CNTW_DEF  = 16;
   localparam int unsigned OCCW      = 2;

   typedef enum logic [OCCW-1:0] {
      OCC_EMPTY = 2'd0,
      OCC_ONE   = 2'd1,
      OCC_TWO   = 2'd2
   } occ_e;

   // A pop may only be issued while a free slot exists
   function automatic logic occ_has_room(input occ_e occ);
      return (occ != OCC_TWO);
   endfunction

endpackage : fifo_rd_stream_pkg

// File: rtl/fifo_rd_stream_skid_buf2.sv
// Generic 2-entry valid/ready buffer. The occupancy register is the state;
// the output word always sits in the head slot.
module skid_buf2
   import fifo_rd_stream_pkg::*;
#(
   parameter int unsigned W = DSIZE_DEF
) (
   input  logic            i_clk,
   input  logic            i_rst,
   input  logic            i_push,
   input  logic [W-1:0]    i_push_data,
   input  logic            i_flush,
   input  logic            i_ready,
   output logic            o_full_c,
   output logic            o_valid,
   output logic [W-1:0]    o_data,
   output logic [OCCW-1:0] o_occ
);

   occ_e         r_state;
   logic [W-1:0] r_head;
   logic [W-1:0] r_tail;
   logic         r_valid;

   assign o_full_c = !occ_has_room(r_state);
   assign o_valid  = r_valid;
   assign o_data   = r_head;
   assign o_occ    = r_state;

   // Flush empties the buffer but keeps slot contents; o_valid masks them
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= OCC_EMPTY;
         r_head  <= '0;
         r_tail  <= '0;
         r_valid <= 1'b0;
      end else if (i_flush) begin
         r_state <= OCC_EMPTY;
         r_valid <= 1'b0;
      end else begin
         unique case (r_state)
            OCC_EMPTY: begin
               if (i_push) begin
                  r_head  <= i_push_data;
                  r_state <= OCC_ONE;
                  r_valid <= 1'b1;
               end
            end
            OCC_ONE: begin
               if (i_push && i_ready) begin
                  r_head <= i_push_data;
               end else if (i_push) begin
                  r_tail  <= i_push_data;
                  r_state <= OCC_TWO;
               end else if (i_ready) begin
                  r_state <= OCC_EMPTY;
                  r_valid <= 1'b0;
               end
            end
            OCC_TWO: begin
               if (i_ready) begin
                  r_head  <= r_tail;
                  r_state <= OCC_ONE;
               end
            end
            default: begin
               r_state <= OCC_EMPTY;
               r_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule : skid_buf2

// File: rtl/fifo_rd_stream.sv
// Read-domain output stage of the async FIFO: pops words into a 2-entry
// buffer and presents them as a valid/ready stream with a delivered count.
module fifo_rd_stream
   import fifo_rd_stream_pkg::*;
#(
   parameter int unsigned DSIZE = DSIZE_DEF,
   parameter int unsigned CNTW  = CNTW_DEF
) (
   input  logic             rclk,
   input  logic             rrst,
   input  logic             empty,
   input  logic [DSIZE-1:0] rdata,
   output logic             rinc,
   input  logic             flush,
   output logic             out_valid,
   output logic [DSIZE-1:0] out_data,
   input  logic             out_ready,
   output logic [OCCW-1:0]  occupancy,
   output logic [CNTW-1:0]  rd_count
);

   logic            w_full;
   logic            w_accept;
   logic [CNTW-1:0] r_rd_count;

   // Pop decision uses only registered state plus empty/flush/rrst, so
   // the consumer's ready never reaches the read pointer combinationally.
   assign rinc     = !empty && !w_full && !flush && !rrst;
   assign w_accept = out_valid && out_ready;
   assign rd_count = r_rd_count;

   skid_buf2 #(
      .W (DSIZE)
   ) u_buf (
      .i_clk       (rclk),
      .i_rst       (rrst),
      .i_push      (rinc),
      .i_push_data (rdata),
      .i_flush     (flush),
      .i_ready     (out_ready),
      .o_full_c    (w_full),
      .o_valid     (out_valid),
      .o_data      (out_data),
      .o_occ       (occupancy)
   );

   // An accept coinciding with flush still counts as delivered
   always_ff @(posedge rclk) begin
      if (rrst) begin
         r_rd_count <= '0;
      end else if (w_accept) begin
         r_rd_count <= r_rd_count + CNTW'(1);
      end
   end

endmodule : fifo_rd_stream

// File: doc/fifo_rd_stream.md
Name: fifo_rd_stream

Overview:
Read-side output stage of the async FIFO, in the read clock domain. It consumes the read-pointer block's empty flag and the memory's read data, and drives its rinc. It presents FIFO contents as a valid/ready stream through a 2-entry skid buffer, so the consumer's ready never combinationally reaches rinc. It also maintains a delivered-word counter and supports a synchronous flush of buffered words.

Parameters:
DSIZE, 8, data word width in bits
CNTW, 16, width of delivered-word counter

Ports:
rclk  input  1  read-domain clock
rrst  input  1  reset; synchronous, active-high
empty  input  1  FIFO empty flag from read-pointer block; exact for the cycle sampled
rdata  input  DSIZE  memory read data at current raddr; combinational, valid in same cycle as !empty
rinc  output  1  pop request to read-pointer block
flush  input  1  discard all buffered words (FIFO contents untouched)
out_valid  output  1  stream word available
out_data  output  DSIZE  stream data
out_ready  input  1  consumer accepts word
occupancy  output  2  buffered word count, 0..2
rd_count  output  CNTW  number of words accepted by consumer, wraps

Behaviour:
- Clock and reset: single clock rclk. rrst is synchronous and active-high, sampled on the rising edge of rclk.
- Reset values: occupancy=0, out_valid=0, out_data=0, rd_count=0, both buffer entries=0.
- rinc is combinational: rinc = !empty && (occupancy < 2) && !flush && !rrst. It depends only on registered state plus empty/flush, never on out_ready.
- Pop: when rinc=1, rdata is captured at the same rising edge. There is no in-flight latency.
- Buffer: 2-entry FIFO with head and tail slot.
  - out_valid = (occupancy != 0).
  - out_data = head entry, registered.
- Accept: out_valid && out_ready. Head advances and rd_count increments by 1 modulo 2^CNTW.
- State machine on occupancy:
  - EMPTY(0): pop -> ONE.
  - ONE(1):
    - pop and no accept -> TWO.
    - pop and accept -> ONE (head replaced by popped word).
    - accept only -> EMPTY.
  - TWO(2): no pop is possible. Accept -> ONE, with tail moving to head.
- Throughput: sustained 1 word/cycle when the FIFO is non-empty and out_ready is held high. The steady state is ONE with simultaneous pop and accept.
- First-word latency: the word is popped at edge N (empty=0 in cycle N-1) and out_valid=1 in cycle N.
- Ordering: strict FIFO order. No loss or duplication.
- Stream rule: once out_valid=1, out_data is held stable until accepted or flushed.
- flush=1:
  - Next edge sets occupancy=0 and out_valid=0.
  - rinc is forced 0 in that cycle.
  - An accept in the same cycle still increments rd_count.
  - rd_count is otherwise not cleared.
- rrst mid-operation: returns to reset values at the next edge. rinc=0 while rrst=1.
- empty=1: rinc=0 regardless of occupancy. The buffered words still drain.

Decomposition:
- Shared package: occupancy encoding constants (OCC_EMPTY=0, OCC_ONE=1, OCC_TWO=2) and default DSIZE/CNTW values, shared with the FIFO top.
- Sub-module: skid_buf2, the generic 2-entry valid/ready buffer (push, push_data, full, valid, ready, data, flush).
- fifo_rd_stream wraps skid_buf2 with the rinc generation logic and rd_count.

Test Plan:
- Reset then idle:
  - rrst=1 for 2 cycles, empty=1.
  - Expect out_valid=0, rinc=0, occupancy=0, rd_count=0.
- Streaming:
  - FIFO holds 0x11,0x22,0x33; out_ready=1 throughout.
  - Expect rinc high for 3 consecutive cycles.
  - Expect out_data 0x11,0x22,0x33 on consecutive cycles and rd_count=3.
- Backpressure:
  - FIFO holds 5 words, out_ready=0.
  - Expect occupancy saturating at 2 and rinc=0 thereafter.
  - Expect out_data held at the first word.
  - Then out_ready=1: expect all 5 delivered in order, rd_count=5.
- Drain to empty:
  - FIFO becomes empty while occupancy=2.
  - Expect rinc=0 and the 2 buffered words still delivered.
  - Expect out_valid=0 afterwards.
- Flush:
  - occupancy=2, flush=1 with out_ready=1.
  - Expect rd_count+1, occupancy=0 and out_valid=0 next cycle, rinc=0 in the flush cycle.
- Counter wrap:
  - CNTW=4, deliver 17 words.
  - Expect rd_count=1.
